// File: rtl/spi_flash_reader.sv
// spi_flash_reader
// SPI mode-0 initiator that fetches one 32-bit little-endian word per request
// from a serial NOR flash using the 0x03 READ command.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   req_valid/req_ready   request channel; req_addr is the flash byte address
//                         (bits [1:0] ignored)
//   rsp_valid/rsp_ready   response channel; rsp_data is the word read
//   sck, csn, mosi, miso  flash pins (sck idles low, csn active low)
//
// Parameters:
//   CLKDIV    SCK half-period in clk cycles (1..255)
//   CSN_HIGH  minimum csn-high cycles between transactions and after reset
module spi_flash_reader #(
    parameter int CLKDIV   = 1,
    parameter int CSN_HIGH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        sck,
    output logic        csn,
    output logic        mosi,
    input  logic        miso
);

    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int CW = $clog2(CSN_HIGH + 1);
    localparam logic [DW-1:0] DIV_RELOAD = DW'(CLKDIV - 1);
    localparam logic [CW-1:0] CS_LOAD    = CW'(CSN_HIGH);
    localparam logic [7:0]    CMD_READ   = 8'h03;

    typedef enum logic [1:0] {IDLE, SHIFT, RESP, DESELECT} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt, div_cnt_nxt;
    logic [CW-1:0] cs_cnt, cs_cnt_nxt;
    logic [5:0]    bit_cnt, bit_cnt_nxt;
    logic [23:0]   addr_q, addr_nxt;
    logic [31:0]   rx_sr, rx_sr_nxt;
    logic [31:0]   cmd_word;
    logic          sck_nxt, csn_nxt, mosi_nxt, req_ready_nxt, rsp_valid_nxt;
    logic [31:0]   rsp_data_nxt;

    assign cmd_word = {CMD_READ, addr_q};

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DESELECT;
            cs_cnt    <= CS_LOAD;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            addr_q    <= '0;
            rx_sr     <= '0;
            sck       <= 1'b0;
            csn       <= 1'b1;
            mosi      <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            cs_cnt    <= cs_cnt_nxt;
            div_cnt   <= div_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            addr_q    <= addr_nxt;
            rx_sr     <= rx_sr_nxt;
            sck       <= sck_nxt;
            csn       <= csn_nxt;
            mosi      <= mosi_nxt;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
        end
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (req_valid) state_nxt = SHIFT;
            SHIFT:    if (div_cnt == '0 && sck && bit_cnt == 6'd63) state_nxt = RESP;
            RESP:     if (rsp_ready) state_nxt = DESELECT;
            DESELECT: if (cs_cnt <= CW'(1)) state_nxt = IDLE;
            default:  state_nxt = DESELECT;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        sck_nxt       = sck;
        csn_nxt       = csn;
        mosi_nxt      = mosi;
        req_ready_nxt = req_ready;
        rsp_valid_nxt = rsp_valid;
        rsp_data_nxt  = rsp_data;
        div_cnt_nxt   = div_cnt;
        cs_cnt_nxt    = cs_cnt;
        bit_cnt_nxt   = bit_cnt;
        addr_nxt      = addr_q;
        rx_sr_nxt     = rx_sr;
        case (state)
            IDLE: begin
                req_ready_nxt = 1'b1;
                if (req_valid) begin
                    req_ready_nxt = 1'b0;
                    csn_nxt       = 1'b0;
                    sck_nxt       = 1'b0;
                    mosi_nxt      = CMD_READ[7];
                    addr_nxt      = req_addr & ~24'h3;
                    bit_cnt_nxt   = '0;
                    div_cnt_nxt   = DIV_RELOAD;
                end
            end
            SHIFT: begin
                if (div_cnt == '0) begin
                    div_cnt_nxt = DIV_RELOAD;
                    if (!sck) begin
                        sck_nxt = 1'b1;
                        // bits 32..63 carry the data word
                        if (bit_cnt[5]) rx_sr_nxt = {rx_sr[30:0], miso};
                    end else begin
                        sck_nxt = 1'b0;
                        if (bit_cnt == 6'd63) begin
                            mosi_nxt      = 1'b0;
                            rsp_valid_nxt = 1'b1;
                            // bytes arrive first-to-last in rx_sr[31:24]..[7:0]
                            rsp_data_nxt  = {rx_sr[7:0], rx_sr[15:8],
                                             rx_sr[23:16], rx_sr[31:24]};
                        end else begin
                            bit_cnt_nxt = bit_cnt + 6'd1;
                            mosi_nxt    = bit_cnt_nxt[5] ? 1'b0
                                                         : cmd_word[~bit_cnt_nxt[4:0]];
                        end
                    end
                end else begin
                    div_cnt_nxt = div_cnt - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    csn_nxt       = 1'b1;
                    cs_cnt_nxt    = CS_LOAD;
                end
            end
            DESELECT: begin
                cs_cnt_nxt = cs_cnt - 1'b1;
                if (cs_cnt <= CW'(1)) req_ready_nxt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
